ow_master_phy: RTL

- Multi-channel 1-Wire bus master timing engine (PHY layer).
- Converts single-slot commands (bus reset/presence, write-0, write-1, read) into open-drain drive enables, one set per channel, for the existing per-channel open-drain pads.
- Supports standard and overdrive speed per command.
- Sits between the byte-level 1-Wire controller and the pad ring. One slot engine is time-shared across all channels.

---
 rtl/ow_master_phy.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/ow_master_phy.sv
// 1-Wire bus master slot engine: one timing engine shared across CH open-drain channels.
// Turns RESET/WRITE0/WRITE1/READ slot commands into per-channel pull-low enables and returns the sampled bit.
module ow_master_phy #(
    parameter int CH      = 4,
    parameter int CHW     = 2,
    parameter int CLK_DIV = 50
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [1:0]     cmd_op,
    input  logic [CHW-1:0] cmd_ch,
    input  logic           cmd_od,
    output logic           rsp_valid,
    output logic           rsp_bit,
    output logic           rsp_err,
    output logic           busy,
    input  logic [CH-1:0]  dq_in,
    output logic [CH-1:0]  dq_out,
    output logic [CH-1:0]  dq_ena
);

    // state  | meaning
    // IDLE   | waiting for a command, cmd_ready high
    // LOW    | addressed line pulled low until t_low
    // HIGH   | line released; sample at t_samp, finish at t_end
    // DONE   | one-cycle response, then back to IDLE
    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

    localparam int            NPAD     = 1 << CHW;
    localparam int            PW       = $clog2(CLK_DIV);
    localparam logic [PW-1:0] LAST_STD = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] LAST_OD  = PW'(CLK_DIV / 4 - 1);
    localparam logic [1:0]    OP_RESET = 2'd0;
    localparam logic [1:0]    OP_WR0   = 2'd1;

    state_t          state_q;
    logic [1:0]      op_q;
    logic [CHW-1:0]  ch_q;
    logic            od_q;
    logic            err_q;
    logic            smp_q;
    logic [PW-1:0]   pre_q;
    logic [PW-1:0]   pre_d;
    logic [9:0]      tick_q;
    logic [9:0]      tick_d;
    logic            tick;
    logic [CH-1:0]   sync1_q;
    logic [CH-1:0]   sync2_q;
    logic [CH-1:0]   dq_ena_q;
    logic            busy_q;
    logic            rsp_valid_q;
    logic            rsp_bit_q;
    logic            rsp_err_q;
    logic [NPAD-1:0] s_pad;
    logic [NPAD-1:0] sel_oh;
    logic            line_acc;
    logic            line_cur;
    logic [9:0]      t_low;
    logic [9:0]      t_samp;
    logic [9:0]      t_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= dq_in;
            sync2_q <= sync1_q;
        end
    end

    // Channels beyond CH read as an idle (high) line and are never driven.
    always_comb begin
        s_pad           = '1;
        s_pad[CH-1:0]   = sync2_q;
        sel_oh          = '0;
        sel_oh[cmd_ch]  = 1'b1;
        line_acc        = s_pad[cmd_ch];
        line_cur        = s_pad[ch_q];
        tick            = (pre_q == (od_q ? LAST_OD : LAST_STD));
        pre_d           = tick ? '0 : pre_q + PW'(1);
        tick_d          = tick_q + 10'd1;
    end

    always_comb begin
        t_low  = 10'd6;
        t_samp = 10'd15;
        t_end  = 10'd70;
        if (!od_q) begin
            if (op_q == OP_RESET) begin
                t_low = 10'd480; t_samp = 10'd550; t_end = 10'd960;
            end else if (op_q == OP_WR0) begin
                t_low = 10'd60;  t_samp = 10'd62;  t_end = 10'd70;
            end
        end else begin
            if (op_q == OP_RESET) begin
                t_low = 10'd280; t_samp = 10'd314; t_end = 10'd440;
            end else if (op_q == OP_WR0) begin
                t_low = 10'd30;  t_samp = 10'd32;  t_end = 10'd40;
            end else begin
                t_low = 10'd4;   t_samp = 10'd8;   t_end = 10'd40;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= 2'd0;
            ch_q        <= '0;
            od_q        <= 1'b0;
            err_q       <= 1'b0;
            smp_q       <= 1'b0;
            pre_q       <= '0;
            tick_q      <= '0;
            dq_ena_q    <= '0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_bit_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q   <= cmd_op;
                        ch_q   <= cmd_ch;
                        od_q   <= cmd_od;
                        pre_q  <= '0;
                        tick_q <= '0;
                        busy_q <= 1'b1;
                        if (!line_acc) begin
                            err_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            err_q    <= 1'b0;
                            dq_ena_q <= sel_oh[CH-1:0];
                            state_q  <= S_LOW;
                        end
                    end
                end
                S_LOW: begin
                    pre_q <= pre_d;
                    if (tick) begin
                        tick_q <= tick_d;
                        if (tick_d == t_low) begin
                            dq_ena_q <= '0;
                            state_q  <= S_HIGH;
                        end
                    end
                end
                S_HIGH: begin
                    pre_q <= pre_d;
                    if (tick) begin
                        tick_q <= tick_d;
                        if (tick_d == t_samp) smp_q <= line_cur;
                        if (tick_d == t_end) state_q <= S_DONE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= err_q;
                    rsp_bit_q   <= err_q ? 1'b0 : ((op_q == OP_RESET) ? ~smp_q : smp_q);
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = ~busy_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_bit   = rsp_bit_q;
    assign rsp_err   = rsp_err_q;
    assign dq_ena    = dq_ena_q;
    assign dq_out    = '0;

endmodule
